// File: rtl/maptable_ckpt.sv
// Rename map table with per-lane bypass and NCKPT in-order branch checkpoints.
// Reads combinational; writes/checkpoints at posedge; mispredict restores in one cycle.
module maptable_ckpt #(
  parameter int WIDTH = 6,
  parameter int AW    = 5,
  parameter int NREN  = 4,
  parameter int NCKPT = 4,
  parameter int CW    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [2*NREN*AW-1:0]      i_raddr,
  output logic [2*NREN*WIDTH-1:0]   o_rdata,
  input  logic [NREN-1:0]           i_we,
  input  logic [NREN*AW-1:0]        i_waddr,
  input  logic [NREN*WIDTH-1:0]     i_wdata,
  output logic [NREN*WIDTH-1:0]     o_oldpd,
  input  logic [NREN-1:0]           i_ckpt_mask,
  output logic [CW-1:0]             o_ckpt_id,
  output logic                      o_full,
  output logic                      o_busy,
  input  logic                      i_resolve_en,
  input  logic [CW-1:0]             i_resolve_id,
  input  logic                      i_mispredict
);
  localparam int NREG = 2**AW;
  localparam int LW   = $clog2(NREN + 1);

  logic [WIDTH-1:0] map_q  [NREG];
  logic [WIDTH-1:0] snap_q [NCKPT][NREG];
  logic [NCKPT-1:0] valid_q;
  logic [CW-1:0]    head_q, tail_q;

  // stage[k] is the map as lane k sees it: committed map plus writes of lanes 0..k-1.
  logic [WIDTH-1:0] stage [NREN+1][NREG];

  logic          ck_hit;
  logic [LW-1:0] ck_sel;
  logic          full, busy;
  logic          res_hit, restore, rel_ok, alloc;
  logic [NCKPT-1:0] kill;
  logic [CW-1:0] dist_s, dist_t;

  always_comb begin
    stage[0] = map_q;
    stage[0][0] = '0;
    for (int k = 0; k < NREN; k++) begin
      stage[k+1] = stage[k];
      if (i_we[k] && (i_waddr[k*AW +: AW] != '0))
        stage[k+1][i_waddr[k*AW +: AW]] = i_wdata[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int s = 0; s < 2*NREN; s++)
      o_rdata[s*WIDTH +: WIDTH] = stage[s/2][i_raddr[s*AW +: AW]];
  end

  always_comb begin
    o_oldpd = '0;
    for (int k = 0; k < NREN; k++)
      o_oldpd[k*WIDTH +: WIDTH] = stage[k][i_waddr[k*AW +: AW]];
  end

  // Lowest set mask bit picks the lane; snapshot includes that lane's own write.
  always_comb begin
    ck_hit = 1'b0;
    ck_sel = '0;
    for (int k = NREN-1; k >= 0; k--) begin
      if (i_ckpt_mask[k]) begin
        ck_hit = 1'b1;
        ck_sel = LW'(k + 1);
      end
    end
  end

  assign full    = (head_q == tail_q) & valid_q[head_q];
  assign busy    = |valid_q;
  assign res_hit = i_resolve_en & valid_q[i_resolve_id];
  assign restore = res_hit & i_mispredict;
  assign rel_ok  = res_hit & ~i_mispredict;
  assign alloc   = ck_hit & ~full & ~restore;

  // Slots id..tail-1 in ring order; id==tail with id valid means the ring is full.
  always_comb begin
    kill   = '0;
    dist_s = '0;
    dist_t = tail_q - i_resolve_id;
    for (int s = 0; s < NCKPT; s++) begin
      dist_s  = CW'(s) - i_resolve_id;
      kill[s] = (dist_t == '0) || (dist_s < dist_t);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      map_q   <= '{default: '0};
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (restore) begin
        map_q   <= snap_q[i_resolve_id];
        valid_q <= valid_q & ~kill;
        tail_q  <= i_resolve_id;
      end else begin
        map_q <= stage[NREN];
        if (rel_ok) valid_q[i_resolve_id] <= 1'b0;
        if (alloc) begin
          valid_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + CW'(1);
        end
      end
      // head==tail with younger slots valid happens after the oldest of a full ring is released.
      if (!valid_q[head_q] && ((head_q != tail_q) || busy))
        head_q <= head_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (alloc) snap_q[tail_q] <= stage[ck_sel];
  end

  assign o_ckpt_id = tail_q;
  assign o_full    = full;
  assign o_busy    = busy;
endmodule

// File: tb/tb_maptable_ckpt.sv
// Directed bench for maptable_ckpt: bypass, checkpoint/restore, full ring, async reset.
module tb_maptable_ckpt;
  localparam int WIDTH = 6, AW = 5, NREN = 4, NCKPT = 4, CW = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [2*NREN*AW-1:0]    i_raddr;
  logic [2*NREN*WIDTH-1:0] o_rdata;
  logic [NREN-1:0]         i_we;
  logic [NREN*AW-1:0]      i_waddr;
  logic [NREN*WIDTH-1:0]   i_wdata;
  logic [NREN*WIDTH-1:0]   o_oldpd;
  logic [NREN-1:0]         i_ckpt_mask;
  logic [CW-1:0]           o_ckpt_id;
  logic                    o_full, o_busy;
  logic                    i_resolve_en;
  logic [CW-1:0]           i_resolve_id;
  logic                    i_mispredict;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] v;

  maptable_ckpt #(.WIDTH(WIDTH), .AW(AW), .NREN(NREN), .NCKPT(NCKPT), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata), .o_oldpd(o_oldpd),
    .i_ckpt_mask(i_ckpt_mask), .o_ckpt_id(o_ckpt_id), .o_full(o_full), .o_busy(o_busy),
    .i_resolve_en(i_resolve_en), .i_resolve_id(i_resolve_id), .i_mispredict(i_mispredict)
  );

  always #10 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic idle();
    i_raddr = '0; i_we = '0; i_waddr = '0; i_wdata = '0; i_ckpt_mask = '0;
    i_resolve_en = 1'b0; i_resolve_id = '0; i_mispredict = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wr(input int lane, input int a, input int d);
    i_we[lane] = 1'b1;
    i_waddr[lane*AW +: AW] = AW'(a);
    i_wdata[lane*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic rd(input int a, output logic [WIDTH-1:0] d);
    i_raddr[0 +: AW] = AW'(a);
    #1;
    d = o_rdata[0 +: WIDTH];
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    #3;
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      for (int s = 0; s < 8; s++) i_raddr[s*AW +: AW] = AW'(g*8 + s);
      #1;
      for (int s = 0; s < 8; s++) begin
        checks++;
        if (o_rdata[s*WIDTH +: WIDTH] !== '0) begin
          errors++;
          $display("FAIL reset_map x%0d got %0d exp 0", g*8 + s, o_rdata[s*WIDTH +: WIDTH]);
        end
      end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", o_busy); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", o_full); end
    checks++; if (o_ckpt_id !== 2'd0) begin errors++; $display("FAIL reset_ckpt_id got %0d exp 0", o_ckpt_id); end
    idle();
    @(negedge i_clk);
  endtask

  task automatic test_bypass();
    idle();
    wr(0, 5, 7); wr(1, 0, 3); wr(2, 5, 9);
    i_waddr[3*AW +: AW] = AW'(5);
    i_raddr[0*AW +: AW] = AW'(5); i_raddr[2*AW +: AW] = AW'(5);
    i_raddr[4*AW +: AW] = AW'(0); i_raddr[6*AW +: AW] = AW'(5);
    #1;
    checks++; if (o_rdata[0*WIDTH +: WIDTH] !== 6'd0) begin errors++; $display("FAIL byp_lane0 got %0d exp 0", o_rdata[0*WIDTH +: WIDTH]); end
    checks++; if (o_rdata[2*WIDTH +: WIDTH] !== 6'd7) begin errors++; $display("FAIL byp_lane1 got %0d exp 7", o_rdata[2*WIDTH +: WIDTH]); end
    checks++; if (o_rdata[4*WIDTH +: WIDTH] !== 6'd0) begin errors++; $display("FAIL byp_x0 got %0d exp 0", o_rdata[4*WIDTH +: WIDTH]); end
    checks++; if (o_rdata[6*WIDTH +: WIDTH] !== 6'd9) begin errors++; $display("FAIL byp_lane3 got %0d exp 9", o_rdata[6*WIDTH +: WIDTH]); end
    checks++; if (o_oldpd[0*WIDTH +: WIDTH] !== 6'd0) begin errors++; $display("FAIL oldpd0 got %0d exp 0", o_oldpd[0*WIDTH +: WIDTH]); end
    checks++; if (o_oldpd[1*WIDTH +: WIDTH] !== 6'd0) begin errors++; $display("FAIL oldpd1 got %0d exp 0", o_oldpd[1*WIDTH +: WIDTH]); end
    checks++; if (o_oldpd[2*WIDTH +: WIDTH] !== 6'd7) begin errors++; $display("FAIL oldpd2 got %0d exp 7", o_oldpd[2*WIDTH +: WIDTH]); end
    checks++; if (o_oldpd[3*WIDTH +: WIDTH] !== 6'd9) begin errors++; $display("FAIL oldpd3 got %0d exp 9", o_oldpd[3*WIDTH +: WIDTH]); end
    tick();
    idle();
    rd(5, v); checks++; if (v !== 6'd9) begin errors++; $display("FAIL wr_highest_lane x5 got %0d exp 9", v); end
    rd(0, v); checks++; if (v !== 6'd0) begin errors++; $display("FAIL wr_x0_dropped got %0d exp 0", v); end
  endtask

  task automatic test_ckpt_restore();
    idle();
    wr(0, 3, 4); wr(2, 3, 8);
    i_ckpt_mask = 4'b0010;
    #1;
    checks++; if (o_ckpt_id !== 2'd0) begin errors++; $display("FAIL ck_id_before got %0d exp 0", o_ckpt_id); end
    tick();
    idle();
    rd(3, v); checks++; if (v !== 6'd8) begin errors++; $display("FAIL ck_map_x3 got %0d exp 8", v); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ck_busy got %0d exp 1", o_busy); end
    checks++; if (o_ckpt_id !== 2'd1) begin errors++; $display("FAIL ck_id_after got %0d exp 1", o_ckpt_id); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd0; i_mispredict = 1'b1;
    tick();
    idle();
    rd(3, v); checks++; if (v !== 6'd4) begin errors++; $display("FAIL restore_x3 got %0d exp 4", v); end
    rd(5, v); checks++; if (v !== 6'd9) begin errors++; $display("FAIL restore_x5 got %0d exp 9", v); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL restore_busy got %0d exp 0", o_busy); end
    checks++; if (o_ckpt_id !== 2'd0) begin errors++; $display("FAIL restore_tail got %0d exp 0", o_ckpt_id); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      idle();
      i_ckpt_mask = 4'b0001;
      #1;
      checks++; if (o_ckpt_id !== CW'(i)) begin errors++; $display("FAIL full_alloc_id got %0d exp %0d", o_ckpt_id, i); end
      tick();
    end
    idle();
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_set got %0d exp 1", o_full); end
    i_ckpt_mask = 4'b0001; wr(0, 6, 2);
    tick();
    idle();
    checks++; if (o_ckpt_id !== 2'd0) begin errors++; $display("FAIL full_ignore_tail got %0d exp 0", o_ckpt_id); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_ignore_full got %0d exp 1", o_full); end
    rd(6, v); checks++; if (v !== 6'd2) begin errors++; $display("FAIL full_write_kept got %0d exp 2", v); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd0;
    tick();
    idle();
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL release_full got %0d exp 0", o_full); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL release_busy got %0d exp 1", o_busy); end
    tick();
    i_ckpt_mask = 4'b0001;
    tick();
    idle();
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL head_advance_full got %0d exp 1", o_full); end
    checks++; if (o_ckpt_id !== 2'd1) begin errors++; $display("FAIL head_advance_tail got %0d exp 1", o_ckpt_id); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd1; i_mispredict = 1'b1;
    tick();
    idle();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_all_busy got %0d exp 0", o_busy); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL flush_all_full got %0d exp 0", o_full); end
    checks++; if (o_ckpt_id !== 2'd1) begin errors++; $display("FAIL flush_all_tail got %0d exp 1", o_ckpt_id); end
    rd(6, v); checks++; if (v !== 6'd0) begin errors++; $display("FAIL flush_all_x6 got %0d exp 0", v); end
    rd(3, v); checks++; if (v !== 6'd4) begin errors++; $display("FAIL flush_all_x3 got %0d exp 4", v); end
  endtask

  task automatic test_mispredict_younger();
    do_reset();
    wr(0, 1, 10); i_ckpt_mask = 4'b0001; tick(); idle();
    wr(0, 2, 12); i_ckpt_mask = 4'b0001; tick(); idle();
    wr(0, 7, 13); i_ckpt_mask = 4'b0001; tick(); idle();
    wr(0, 1, 20); tick(); idle();
    checks++; if (o_ckpt_id !== 2'd3) begin errors++; $display("FAIL young_tail got %0d exp 3", o_ckpt_id); end
    rd(1, v); checks++; if (v !== 6'd20) begin errors++; $display("FAIL young_x1_pre got %0d exp 20", v); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd1; i_mispredict = 1'b1;
    wr(0, 7, 11); i_ckpt_mask = 4'b0001;
    tick();
    idle();
    rd(7, v); checks++; if (v !== 6'd0) begin errors++; $display("FAIL young_x7 got %0d exp 0", v); end
    rd(1, v); checks++; if (v !== 6'd10) begin errors++; $display("FAIL young_x1 got %0d exp 10", v); end
    rd(2, v); checks++; if (v !== 6'd12) begin errors++; $display("FAIL young_x2 got %0d exp 12", v); end
    checks++; if (o_ckpt_id !== 2'd1) begin errors++; $display("FAIL young_tail_post got %0d exp 1", o_ckpt_id); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL young_busy got %0d exp 1", o_busy); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd2; i_mispredict = 1'b1; wr(0, 9, 5);
    tick();
    idle();
    rd(9, v); checks++; if (v !== 6'd5) begin errors++; $display("FAIL invalid_id_write got %0d exp 5", v); end
    rd(1, v); checks++; if (v !== 6'd10) begin errors++; $display("FAIL invalid_id_x1 got %0d exp 10", v); end
    checks++; if (o_ckpt_id !== 2'd1) begin errors++; $display("FAIL invalid_id_tail got %0d exp 1", o_ckpt_id); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd0; i_ckpt_mask = 4'b0001;
    tick();
    idle();
    checks++; if (o_ckpt_id !== 2'd2) begin errors++; $display("FAIL res_alloc_tail got %0d exp 2", o_ckpt_id); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL res_alloc_busy got %0d exp 1", o_busy); end
    i_resolve_en = 1'b1; i_resolve_id = 2'd1; i_mispredict = 1'b1;
    tick();
    idle();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL res_alloc_clear got %0d exp 0", o_busy); end
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      wr(0, 4, 33); i_ckpt_mask = 4'b0001; tick(); idle();
    end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %0d exp 1", o_busy); end
    #3 i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %0d exp 0", o_busy); end
    checks++; if (o_ckpt_id !== 2'd0) begin errors++; $display("FAIL arst_tail got %0d exp 0", o_ckpt_id); end
    rd(4, v); checks++; if (v !== 6'd0) begin errors++; $display("FAIL arst_x4 got %0d exp 0", v); end
    rd(1, v); checks++; if (v !== 6'd0) begin errors++; $display("FAIL arst_x1 got %0d exp 0", v); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_after_busy got %0d exp 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ckpt_restore();
    test_full();
    test_mispredict_younger();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
